imem_port_arbiter: RTL and testbench

Two-port access arbiter for the synchronous-read instruction ROM (128 words x 32 bits, one-cycle registered read). It shares the single ROM read port between the CPU fetch port and a debug/monitor readback port, and steers each returned word to the port that requested it. CPU fetch has priority, with a bounded-wait guarantee for the debug port. It sits between the CPU fetch logic and the ROM's address input.

---
 rtl/imem_port_arbiter.sv | 80 ++++++++
 tb/tb_imem_port_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// Shares the single registered-read instruction ROM port between CPU fetch and debug readback.
// CPU has priority; debug is guaranteed a grant after MAX_WAIT consecutive CPU wins.
module imem_port_arbiter #(
  parameter int unsigned AW       = 7,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        c_req,
  input  logic [31:0] c_addr,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        c_err,
  output logic        c_stall,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] rom_a,
  input  logic [31:0] rom_inst
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, CPU_RD, DBG_RD} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   last_addr;
  logic          err_q;
  logic          d_win;
  logic          c_oor;
  logic          d_oor;

  assign c_oor = (c_addr[31:AW+2] != '0);
  assign d_oor = (d_addr[31:AW+2] != '0);

  // Debug wins when the CPU is idle or has exhausted its consecutive-win budget.
  assign d_win   = d_req & (~c_req | (wait_cnt == WAIT_MAX));
  assign c_gnt   = clrn & c_req & ~d_win;
  assign d_gnt   = clrn & d_win;
  assign c_stall = clrn & c_req & ~c_gnt;

  // Holding the last granted address keeps the ROM input stable between accesses.
  assign rom_a = c_gnt ? c_addr : (d_gnt ? d_addr : last_addr);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      err_q     <= 1'b0;
      last_addr <= '0;
      wait_cnt  <= '0;
    end else begin
      if (c_gnt)      state <= CPU_RD;
      else if (d_gnt) state <= DBG_RD;
      else            state <= IDLE;

      err_q <= (c_gnt & c_oor) | (d_gnt & d_oor);

      if (c_gnt || d_gnt) last_addr <= rom_a;

      if (d_gnt || !d_req)
        wait_cnt <= '0;
      else if (c_gnt && (wait_cnt < WAIT_MAX))
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign c_rvalid = (state == CPU_RD);
  assign d_rvalid = (state == DBG_RD);
  assign c_err    = c_rvalid & err_q;
  assign d_err    = d_rvalid & err_q;
  assign c_rdata  = (c_rvalid & ~err_q) ? rom_inst : '0;
  assign d_rdata  = (d_rvalid & ~err_q) ? rom_inst : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 128x32 registered-read ROM.
module tb_imem_port_arbiter;

  logic        clk;
  logic        clrn;
  logic        c_req;
  logic [31:0] c_addr;
  logic        c_gnt;
  logic        c_rvalid;
  logic [31:0] c_rdata;
  logic        c_err;
  logic        c_stall;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] rom_a;
  logic [31:0] rom_inst;

  int n_checks;
  int n_fail;

  imem_port_arbiter #(.AW(7), .MAX_WAIT(4)) dut (
    .clk      (clk),
    .clrn     (clrn),
    .c_req    (c_req),
    .c_addr   (c_addr),
    .c_gnt    (c_gnt),
    .c_rvalid (c_rvalid),
    .c_rdata  (c_rdata),
    .c_err    (c_err),
    .c_stall  (c_stall),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .rom_a    (rom_a),
    .rom_inst (rom_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_val(input logic [6:0] idx);
    return 32'hC0DE_0000 + 32'({25'd0, idx}) * 32'h0000_0101;
  endfunction

  always_ff @(posedge clk) rom_inst <= rom_val(rom_a[8:2]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clrn     = 1'b0;
    c_req    = 1'b1;
    c_addr   = 32'h10;
    d_req    = 1'b1;
    d_addr   = 32'h20;
    sample();
    check("rst_c_gnt", 32'(c_gnt), 32'd0);
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    check("rst_c_stall", 32'(c_stall), 32'd0);
    check("rst_rom_a", rom_a, 32'd0);
    check("rst_rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd0);
    check("rst_rdata", c_rdata | d_rdata, 32'd0);
    tick();
    c_req = 1'b0;
    d_req = 1'b0;
    tick();
    clrn = 1'b1;

    // CPU back-to-back reads of words 0,1,2
    tick();
    c_req = 1'b1; c_addr = 32'h0;
    sample();
    check("cpu0_gnt", 32'(c_gnt), 32'd1);
    check("cpu0_rom_a", rom_a, 32'h0);
    check("cpu0_rvalid", 32'(c_rvalid), 32'd0);
    tick(); c_addr = 32'h4;
    sample();
    check("cpu1_gnt", 32'(c_gnt), 32'd1);
    check("cpu1_rdata", c_rdata, rom_val(7'd0));
    check("cpu1_d_quiet", {d_gnt, d_rvalid, d_err, d_rdata[28:0]}, 32'd0);
    tick(); c_addr = 32'h8;
    sample();
    check("cpu2_rdata", c_rdata, rom_val(7'd1));
    tick(); c_req = 1'b0; c_addr = 32'h44;
    sample();
    check("cpu3_rvalid", 32'(c_rvalid), 32'd1);
    check("cpu3_rdata", c_rdata, rom_val(7'd2));
    check("cpu3_gnt", 32'(c_gnt), 32'd0);
    check("cpu3_rom_hold", rom_a, 32'h8);
    tick();
    sample();
    check("cpu4_rvalid", 32'(c_rvalid), 32'd0);
    check("cpu4_rdata", c_rdata, 32'd0);

    // Contention: debug forced in after four CPU grants
    tick();
    c_req = 1'b1; c_addr = 32'h40; d_req = 1'b1; d_addr = 32'h10;
    for (int k = 0; k < 7; k++) begin
      sample();
      check($sformatf("cont%0d_c_gnt", k), 32'(c_gnt), 32'(k != 4));
      check($sformatf("cont%0d_d_gnt", k), 32'(d_gnt), 32'(k == 4));
      check($sformatf("cont%0d_stall", k), 32'(c_stall), 32'(k == 4));
      check($sformatf("cont%0d_d_rvalid", k), 32'(d_rvalid), 32'(k == 5));
      if (k == 5) begin
        check("cont5_d_rdata", d_rdata, rom_val(7'd4));
        check("cont5_c_rvalid", 32'(c_rvalid), 32'd0);
      end
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    tick();

    // Idle CPU, debug reads the top word
    d_req = 1'b1; d_addr = 32'h1FC;
    sample();
    check("dbg_gnt", 32'(d_gnt), 32'd1);
    check("dbg_rom_a", rom_a, 32'h1FC);
    tick(); d_req = 1'b0;
    sample();
    check("dbg_rvalid", 32'(d_rvalid), 32'd1);
    check("dbg_rdata", d_rdata, rom_val(7'd127));
    check("dbg_err", 32'(d_err), 32'd0);
    tick();

    // Out of range, then misaligned in-range
    c_req = 1'b1; c_addr = 32'h200;
    tick(); c_addr = 32'h7;
    sample();
    check("oor_rvalid", 32'(c_rvalid), 32'd1);
    check("oor_err", 32'(c_err), 32'd1);
    check("oor_rdata", c_rdata, 32'd0);
    tick(); c_req = 1'b0;
    sample();
    check("mis_rvalid", 32'(c_rvalid), 32'd1);
    check("mis_err", 32'(c_err), 32'd0);
    check("mis_rdata", c_rdata, rom_val(7'd1));
    tick();

    // d_req dropped at wait_cnt=3 restarts the count
    c_req = 1'b1; c_addr = 32'h0; d_req = 1'b1; d_addr = 32'h30;
    for (int k = 0; k < 3; k++) begin
      sample();
      check($sformatf("drop_pre%0d_c_gnt", k), 32'(c_gnt), 32'd1);
      tick();
    end
    d_req = 1'b0;
    sample();
    check("drop_gap_c_gnt", 32'(c_gnt), 32'd1);
    tick(); d_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample();
      check($sformatf("drop_post%0d_d_gnt", k), 32'(d_gnt), 32'(k == 4));
      tick();
    end
    c_req = 1'b0; d_req = 1'b0;
    tick();

    // Reset pulsed the cycle after a grant drops the in-flight read
    c_req = 1'b1; c_addr = 32'h20;
    sample();
    check("mid_gnt", 32'(c_gnt), 32'd1);
    tick();
    clrn = 1'b0; c_req = 1'b0;
    sample();
    check("mid_rst_rvalid", 32'(c_rvalid), 32'd0);
    check("mid_rst_rom_a", rom_a, 32'd0);
    tick();
    clrn = 1'b1;
    sample();
    check("mid_rel_rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd0);
    check("mid_rel_rom_a", rom_a, 32'd0);
    tick();
    sample();
    check("mid_rel2_rvalid", {30'd0, c_rvalid, d_rvalid}, 32'd0);
    check("mid_rel2_rdata", c_rdata | d_rdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
